// File: rtl/tcp_send_pattern_gen.sv
// -----------------------------------------------------------------------------
// tcp_send_pattern_gen
// Generates TCP TX test traffic. On a rising edge of the start bit it latches
// a job (length, op count, offset, session). For each op it emits one
// metadata beat followed by length/64 data words carrying an incrementing
// 32-bit counter. Counters and state are exposed on status_reg.
//
// Ports
//   clk, rstn                 : clock, asynchronous active-low reset
//   m_axis_tx_metadata_*      : metadata stream {length[15:0], session[15:0]}
//   m_axis_tx_data_*          : payload stream (data/keep/last)
//   control_reg[16]           : [0] bit0 start, [1] tcp_length, [2] ops,
//                               [3] offset, [4] session id in bits [15:0]
//   status_reg[8]             : [0] busy cycles, [1] ops done, [2] words sent,
//                               [3] state, [4..7] zero
// -----------------------------------------------------------------------------
module tcp_send_pattern_gen #(
   parameter int unsigned DATA_WIDTH = 512
) (
   input  logic                      clk,
   input  logic                      rstn,
   output logic                      m_axis_tx_metadata_valid,
   input  logic                      m_axis_tx_metadata_ready,
   output logic [31:0]               m_axis_tx_metadata_data,
   output logic                      m_axis_tx_data_valid,
   input  logic                      m_axis_tx_data_ready,
   output logic [DATA_WIDTH-1:0]     m_axis_tx_data_data,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tx_data_keep,
   output logic                      m_axis_tx_data_last,
   input  logic [15:0][31:0]         control_reg,
   output logic [7:0][31:0]          status_reg
);

   localparam int unsigned KEEP_W = DATA_WIDTH / 8;
   localparam int unsigned WCNT_W = 10;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_META = 3'b010,
      S_DATA = 3'b100
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_start_q1;
   logic                r_start_q2;
   logic                w_start_evt;

   logic [WCNT_W-1:0]   r_words;
   logic [31:0]         r_ops;
   logic [31:0]         r_offset;
   logic [15:0]         r_session;

   logic [WCNT_W-1:0]   r_idx;
   logic [WCNT_W-1:0]   w_idx_nxt;
   logic [31:0]         r_ops_done;
   logic [31:0]         w_ops_done_nxt;
   logic [31:0]         r_busy_cnt;
   logic [31:0]         r_words_sent;

   logic                w_accept;
   logic                w_meta_hs;
   logic                w_data_hs;
   logic                w_last_word;
   logic [WCNT_W-1:0]   w_cfg_words;

   logic [WCNT_W-1:0]   w_words_nxt;
   logic [31:0]         w_offset_nxt;
   logic [15:0]         w_session_nxt;

   logic                w_unused;

   assign w_cfg_words  = control_reg[1][15:6];
   assign w_start_evt  = r_start_q1 & ~r_start_q2;
   assign w_meta_hs    = m_axis_tx_metadata_valid & m_axis_tx_metadata_ready;
   assign w_data_hs    = m_axis_tx_data_valid & m_axis_tx_data_ready;
   assign w_last_word  = (r_idx == (r_words - WCNT_W'(1)));

   // Job parameters as they will be after this cycle (new values on accept)
   assign w_words_nxt   = w_accept ? w_cfg_words         : r_words;
   assign w_offset_nxt  = w_accept ? control_reg[3]      : r_offset;
   assign w_session_nxt = w_accept ? control_reg[4][15:0] : r_session;

   // Ignored control bits
   assign w_unused = ^{control_reg[15:5], control_reg[4][31:16],
                       control_reg[1][31:16], control_reg[1][5:0],
                       control_reg[0][31:1]};

   // Start synchroniser; flops reset high so a start bit held high through
   // reset looks like a steady level, not an edge, after release
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_start_q1 <= 1'b1;
         r_start_q2 <= 1'b1;
      end else begin
         r_start_q1 <= control_reg[0][0];
         r_start_q2 <= r_start_q1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and counter update logic
   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_ops_done_nxt = r_ops_done;
      w_accept       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_evt && (control_reg[2] != 32'd0) && (w_cfg_words != WCNT_W'(0))) begin
               w_accept       = 1'b1;
               w_state_nxt    = S_META;
               w_idx_nxt      = WCNT_W'(0);
               w_ops_done_nxt = 32'd0;
            end
         end
         S_META: begin
            if (w_meta_hs) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_data_hs) begin
               if (w_last_word) begin
                  w_idx_nxt      = WCNT_W'(0);
                  w_ops_done_nxt = r_ops_done + 32'd1;
                  w_state_nxt    = ((r_ops_done + 32'd1) == r_ops) ? S_IDLE : S_META;
               end else begin
                  w_idx_nxt = r_idx + WCNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Job latch and counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_words      <= '0;
         r_ops        <= '0;
         r_offset     <= '0;
         r_session    <= '0;
         r_idx        <= '0;
         r_ops_done   <= '0;
         r_busy_cnt   <= '0;
         r_words_sent <= '0;
      end else begin
         r_words    <= w_words_nxt;
         r_offset   <= w_offset_nxt;
         r_session  <= w_session_nxt;
         r_idx      <= w_idx_nxt;
         r_ops_done <= w_ops_done_nxt;
         if (w_accept) begin
            r_ops <= control_reg[2];
         end
         if (w_accept) begin
            r_busy_cnt <= '0;
         end else if ((r_state != S_IDLE) && (r_busy_cnt != 32'hFFFF_FFFF)) begin
            r_busy_cnt <= r_busy_cnt + 32'd1;
         end
         if (w_data_hs) begin
            r_words_sent <= r_words_sent + 32'd1;
         end
      end
   end

   // Registered stream outputs, driven from the next state so valid and
   // payload line up with the state register and hold while stalled
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_axis_tx_metadata_valid <= 1'b0;
         m_axis_tx_metadata_data  <= '0;
         m_axis_tx_data_valid     <= 1'b0;
         m_axis_tx_data_data      <= '0;
         m_axis_tx_data_keep      <= '0;
         m_axis_tx_data_last      <= 1'b0;
      end else begin
         m_axis_tx_metadata_valid <= (w_state_nxt == S_META);
         m_axis_tx_metadata_data  <= (w_state_nxt == S_META) ?
                                     {w_words_nxt, 6'b0, w_session_nxt} : 32'd0;
         m_axis_tx_data_valid     <= (w_state_nxt == S_DATA);
         m_axis_tx_data_data      <= (w_state_nxt == S_DATA) ?
                                     DATA_WIDTH'(w_offset_nxt + 32'(w_idx_nxt)) : '0;
         m_axis_tx_data_keep      <= (w_state_nxt == S_DATA) ? {KEEP_W{1'b1}} : '0;
         m_axis_tx_data_last      <= (w_state_nxt == S_DATA) &&
                                     (w_idx_nxt == (w_words_nxt - WCNT_W'(1)));
      end
   end

   assign status_reg[0] = r_busy_cnt;
   assign status_reg[1] = r_ops_done;
   assign status_reg[2] = r_words_sent;
   assign status_reg[3] = 32'(r_state);
   assign status_reg[4] = 32'd0;
   assign status_reg[5] = 32'd0;
   assign status_reg[6] = 32'd0;
   assign status_reg[7] = 32'd0;

endmodule

// File: tb/tb_tcp_send_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_tcp_send_pattern_gen
// Directed bench for tcp_send_pattern_gen: one task per scenario, each with
// hand-computed expected metadata, payload words, last flags and status.
// -----------------------------------------------------------------------------
module tb_tcp_send_pattern_gen;

   localparam int DW = 512;
   localparam int KW = DW / 8;

   logic              clk  = 1'b0;
   logic              rstn = 1'b1;
   logic              meta_valid;
   logic              meta_ready;
   logic [31:0]       meta_data;
   logic              data_valid;
   logic              data_ready;
   logic [DW-1:0]     data_data;
   logic [KW-1:0]     data_keep;
   logic              data_last;
   logic [15:0][31:0] control_reg;
   logic [7:0][31:0]  status_reg;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] cap_meta[$];
   logic [31:0] cap_word[$];
   logic        cap_last[$];
   int          overlap_cnt;
   int          unstable_cnt;
   int          payload_bad;
   int          valid_cycles;

   always #5 clk = ~clk;

   tcp_send_pattern_gen #(.DATA_WIDTH(DW)) dut (
      .clk                      (clk),
      .rstn                     (rstn),
      .m_axis_tx_metadata_valid (meta_valid),
      .m_axis_tx_metadata_ready (meta_ready),
      .m_axis_tx_metadata_data  (meta_data),
      .m_axis_tx_data_valid     (data_valid),
      .m_axis_tx_data_ready     (data_ready),
      .m_axis_tx_data_data      (data_data),
      .m_axis_tx_data_keep      (data_keep),
      .m_axis_tx_data_last      (data_last),
      .control_reg              (control_reg),
      .status_reg               (status_reg)
   );

   // Runs a fixed number of cycles collecting handshakes; called #1 after a
   // posedge with start already raised. Start drops at cycle 3. A nonzero
   // mid_cycle re-pulses start and rewrites length/ops during the job.
   task automatic run_job(input int cycles, input bit toggle, input int mid_cycle);
      logic [DW-1:0] h_data;
      logic          h_last;
      logic          h_dvalid;
      logic [31:0]   h_meta;
      logic          h_mvalid;
      cap_meta.delete();
      cap_word.delete();
      cap_last.delete();
      overlap_cnt  = 0;
      unstable_cnt = 0;
      payload_bad  = 0;
      valid_cycles = 0;
      h_dvalid = 1'b0;
      h_mvalid = 1'b0;
      h_data   = '0;
      h_last   = 1'b0;
      h_meta   = '0;
      for (int c = 0; c < cycles; c++) begin
         if (c == 3) control_reg[0][0] = 1'b0;
         if (mid_cycle > 0 && c == mid_cycle) begin
            control_reg[0][0] = 1'b1;
            control_reg[1]    = 32'd1024;
            control_reg[2]    = 32'd5;
         end
         if (mid_cycle > 0 && c == mid_cycle + 3) control_reg[0][0] = 1'b0;
         if (h_dvalid && (!data_valid || data_data !== h_data || data_last !== h_last))
            unstable_cnt++;
         if (h_mvalid && (!meta_valid || meta_data !== h_meta))
            unstable_cnt++;
         if (meta_valid && data_valid) overlap_cnt++;
         if (meta_valid || data_valid) valid_cycles++;
         if (data_valid && (data_keep !== {KW{1'b1}} || data_data[DW-1:32] !== '0))
            payload_bad++;
         data_ready = toggle ? 1'(c % 2 == 1) : 1'b1;
         meta_ready = toggle ? 1'(c % 2 == 0) : 1'b1;
         if (data_valid && data_ready) begin
            cap_word.push_back(data_data[31:0]);
            cap_last.push_back(data_last);
         end
         if (meta_valid && meta_ready) cap_meta.push_back(meta_data);
         h_dvalid = data_valid && !data_ready;
         h_data   = data_data;
         h_last   = data_last;
         h_mvalid = meta_valid && !meta_ready;
         h_meta   = meta_data;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      control_reg = '0;
      meta_ready  = 1'b0;
      data_ready  = 1'b0;
      #2 rstn = 1'b0;
      #20;
      n_checks++; if (meta_valid !== 1'b0) $display("FAIL reset_meta_valid got %b want 0", meta_valid); else n_pass++;
      n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid got %b want 0", data_valid); else n_pass++;
      n_checks++; if (data_last !== 1'b0) $display("FAIL reset_last got %b want 0", data_last); else n_pass++;
      n_checks++; if (data_data !== '0) $display("FAIL reset_data got %h want 0", data_data[63:0]); else n_pass++;
      n_checks++; if (data_keep !== '0) $display("FAIL reset_keep got %h want 0", data_keep); else n_pass++;
      n_checks++; if (meta_data !== 32'd0) $display("FAIL reset_meta_data got %h want 0", meta_data); else n_pass++;
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL reset_state got %h want 1", status_reg[3]); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (status_reg[i] !== 32'd0) $display("FAIL reset_status%0d got %h want 0", i, status_reg[i]); else n_pass++;
      end
      for (int i = 4; i < 8; i++) begin
         n_checks++;
         if (status_reg[i] !== 32'd0) $display("FAIL reset_status%0d got %h want 0", i, status_reg[i]); else n_pass++;
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL post_reset_state got %h want 1", status_reg[3]); else n_pass++;
   endtask

   task automatic test_basic();
      logic [31:0] exp_w;
      control_reg[1] = 32'd256;
      control_reg[2] = 32'd2;
      control_reg[3] = 32'h100;
      control_reg[4] = 32'd7;
      control_reg[0][0] = 1'b1;
      run_job(40, 1'b0, 0);
      n_checks++; if (cap_meta.size() != 2) $display("FAIL basic_meta_count got %0d want 2", cap_meta.size()); else n_pass++;
      for (int i = 0; i < cap_meta.size(); i++) begin
         n_checks++;
         if (cap_meta[i] !== 32'h0100_0007) $display("FAIL basic_meta%0d got %h want 01000007", i, cap_meta[i]); else n_pass++;
      end
      n_checks++; if (cap_word.size() != 8) $display("FAIL basic_word_count got %0d want 8", cap_word.size()); else n_pass++;
      for (int i = 0; i < cap_word.size(); i++) begin
         exp_w = 32'h100 + 32'(i % 4);
         n_checks++;
         if (cap_word[i] !== exp_w) $display("FAIL basic_word%0d got %h want %h", i, cap_word[i], exp_w); else n_pass++;
         n_checks++;
         if (cap_last[i] !== 1'(i % 4 == 3)) $display("FAIL basic_last%0d got %b want %b", i, cap_last[i], (i % 4 == 3)); else n_pass++;
      end
      n_checks++; if (status_reg[1] !== 32'd2) $display("FAIL basic_ops_done got %0d want 2", status_reg[1]); else n_pass++;
      n_checks++; if (status_reg[2] !== 32'd8) $display("FAIL basic_words_sent got %0d want 8", status_reg[2]); else n_pass++;
      n_checks++; if (status_reg[0] !== 32'd10) $display("FAIL basic_busy got %0d want 10", status_reg[0]); else n_pass++;
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL basic_state got %h want 1", status_reg[3]); else n_pass++;
      n_checks++; if (overlap_cnt != 0) $display("FAIL basic_overlap got %0d want 0", overlap_cnt); else n_pass++;
      n_checks++; if (payload_bad != 0) $display("FAIL basic_keep_upper got %0d want 0", payload_bad); else n_pass++;
   endtask

   task automatic test_stall();
      logic [31:0] exp_w;
      control_reg[1] = 32'd256;
      control_reg[2] = 32'd2;
      control_reg[3] = 32'h100;
      control_reg[4] = 32'd7;
      control_reg[0][0] = 1'b1;
      run_job(60, 1'b1, 0);
      n_checks++; if (cap_meta.size() != 2) $display("FAIL stall_meta_count got %0d want 2", cap_meta.size()); else n_pass++;
      n_checks++; if (cap_word.size() != 8) $display("FAIL stall_word_count got %0d want 8", cap_word.size()); else n_pass++;
      for (int i = 0; i < cap_word.size(); i++) begin
         exp_w = 32'h100 + 32'(i % 4);
         n_checks++;
         if (cap_word[i] !== exp_w || cap_last[i] !== 1'(i % 4 == 3))
            $display("FAIL stall_word%0d got %h/%b want %h/%b", i, cap_word[i], cap_last[i], exp_w, (i % 4 == 3));
         else n_pass++;
      end
      n_checks++; if (unstable_cnt != 0) $display("FAIL stall_stable got %0d changes want 0", unstable_cnt); else n_pass++;
      n_checks++; if (overlap_cnt != 0) $display("FAIL stall_overlap got %0d want 0", overlap_cnt); else n_pass++;
      n_checks++; if (status_reg[1] !== 32'd2) $display("FAIL stall_ops_done got %0d want 2", status_reg[1]); else n_pass++;
      n_checks++; if (status_reg[2] !== 32'd16) $display("FAIL stall_words_sent got %0d want 16", status_reg[2]); else n_pass++;
   endtask

   task automatic test_no_start();
      control_reg[1] = 32'd256;
      control_reg[2] = 32'd0;
      control_reg[3] = 32'd0;
      control_reg[4] = 32'd7;
      control_reg[0][0] = 1'b1;
      run_job(20, 1'b0, 0);
      n_checks++; if (valid_cycles != 0) $display("FAIL zero_ops_valid got %0d cycles want 0", valid_cycles); else n_pass++;
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL zero_ops_state got %h want 1", status_reg[3]); else n_pass++;
      control_reg[1] = 32'd32;
      control_reg[2] = 32'd2;
      control_reg[0][0] = 1'b1;
      run_job(20, 1'b0, 0);
      n_checks++; if (valid_cycles != 0) $display("FAIL short_len_valid got %0d cycles want 0", valid_cycles); else n_pass++;
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL short_len_state got %h want 1", status_reg[3]); else n_pass++;
      n_checks++; if (status_reg[2] !== 32'd16) $display("FAIL no_start_words_sent got %0d want 16", status_reg[2]); else n_pass++;
   endtask

   task automatic test_single_word();
      control_reg[1] = 32'd64;
      control_reg[2] = 32'd3;
      control_reg[3] = 32'hFFFF_FFFF;
      control_reg[4] = 32'd7;
      control_reg[0][0] = 1'b1;
      run_job(30, 1'b0, 0);
      n_checks++; if (cap_meta.size() != 3) $display("FAIL single_meta_count got %0d want 3", cap_meta.size()); else n_pass++;
      for (int i = 0; i < cap_meta.size(); i++) begin
         n_checks++;
         if (cap_meta[i] !== 32'h0040_0007) $display("FAIL single_meta%0d got %h want 00400007", i, cap_meta[i]); else n_pass++;
      end
      n_checks++; if (cap_word.size() != 3) $display("FAIL single_word_count got %0d want 3", cap_word.size()); else n_pass++;
      for (int i = 0; i < cap_word.size(); i++) begin
         n_checks++;
         if (cap_word[i] !== 32'hFFFF_FFFF || cap_last[i] !== 1'b1)
            $display("FAIL single_word%0d got %h/%b want ffffffff/1", i, cap_word[i], cap_last[i]);
         else n_pass++;
      end
      n_checks++; if (status_reg[1] !== 32'd3) $display("FAIL single_ops_done got %0d want 3", status_reg[1]); else n_pass++;
      n_checks++; if (status_reg[2] !== 32'd19) $display("FAIL single_words_sent got %0d want 19", status_reg[2]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w;
      control_reg[1] = 32'h5A5A_013F;
      control_reg[2] = 32'd3;
      control_reg[3] = 32'h20;
      control_reg[4] = 32'hABCD_1234;
      control_reg[0][0] = 1'b1;
      run_job(50, 1'b0, 6);
      n_checks++; if (cap_meta.size() != 3) $display("FAIL b2b_meta_count got %0d want 3", cap_meta.size()); else n_pass++;
      for (int i = 0; i < cap_meta.size(); i++) begin
         n_checks++;
         if (cap_meta[i] !== 32'h0100_1234) $display("FAIL b2b_meta%0d got %h want 01001234", i, cap_meta[i]); else n_pass++;
      end
      n_checks++; if (cap_word.size() != 12) $display("FAIL b2b_word_count got %0d want 12", cap_word.size()); else n_pass++;
      for (int i = 0; i < cap_word.size(); i++) begin
         exp_w = 32'h20 + 32'(i % 4);
         n_checks++;
         if (cap_word[i] !== exp_w || cap_last[i] !== 1'(i % 4 == 3))
            $display("FAIL b2b_word%0d got %h/%b want %h/%b", i, cap_word[i], cap_last[i], exp_w, (i % 4 == 3));
         else n_pass++;
      end
      n_checks++; if (status_reg[1] !== 32'd3) $display("FAIL b2b_ops_done got %0d want 3", status_reg[1]); else n_pass++;
      n_checks++; if (status_reg[2] !== 32'd31) $display("FAIL b2b_words_sent got %0d want 31", status_reg[2]); else n_pass++;
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL b2b_state got %h want 1", status_reg[3]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit found;
      control_reg[1] = 32'd256;
      control_reg[2] = 32'd2;
      control_reg[3] = 32'h100;
      control_reg[4] = 32'd7;
      control_reg[0][0] = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         if (c == 3) control_reg[0][0] = 1'b0;
         data_ready = 1'b1;
         meta_ready = 1'b1;
         if (data_valid && data_data[31:0] == 32'h101) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_checks++; if (found !== 1'b1) $display("FAIL rmid_reach_word1 got %b want 1", found); else n_pass++;
      rstn = 1'b0;
      #1;
      n_checks++; if (meta_valid !== 1'b0 || data_valid !== 1'b0) $display("FAIL rmid_valids got %b%b want 00", meta_valid, data_valid); else n_pass++;
      n_checks++; if (data_data !== '0 || data_keep !== '0 || data_last !== 1'b0) $display("FAIL rmid_payload got %h/%b want 0/0", data_data[31:0], data_last); else n_pass++;
      n_checks++; if (status_reg[2] !== 32'd0) $display("FAIL rmid_words_sent got %0d want 0", status_reg[2]); else n_pass++;
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL rmid_state got %h want 1", status_reg[3]); else n_pass++;
      control_reg[0][0] = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b1;
      run_job(15, 1'b0, 0);
      n_checks++; if (valid_cycles != 0) $display("FAIL rmid_held_start got %0d valid cycles want 0", valid_cycles); else n_pass++;
      n_checks++; if (status_reg[3] !== 32'd1) $display("FAIL rmid_idle got %h want 1", status_reg[3]); else n_pass++;
      control_reg[0][0] = 1'b1;
      run_job(40, 1'b0, 0);
      n_checks++; if (cap_meta.size() != 2) $display("FAIL rmid_restart_meta got %0d want 2", cap_meta.size()); else n_pass++;
      n_checks++; if (cap_word.size() != 8) $display("FAIL rmid_restart_words got %0d want 8", cap_word.size()); else n_pass++;
      if (cap_word.size() > 0) begin
         n_checks++;
         if (cap_word[0] !== 32'h100) $display("FAIL rmid_first_word got %h want 00000100", cap_word[0]); else n_pass++;
      end
      n_checks++; if (status_reg[2] !== 32'd8) $display("FAIL rmid_words_sent_after got %0d want 8", status_reg[2]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_no_start();
      test_single_word();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
